// File: rtl/uart_cmd_pkg.sv
// Shared types for the UART command/response framer.
//   BYTE_W     : width of one serial byte
//   rx_state_t : command assembler states (R_IDLE = index 0, R_ASM = mid-frame)
//   tx_state_t : response serialiser states
package uart_cmd_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        R_IDLE,
        R_ASM
    } rx_state_t;

    typedef enum logic [1:0] {
        T_IDLE,
        T_SEND,
        T_WAIT
    } tx_state_t;

endpackage

// File: rtl/UART.sv
// Byte-level UART core: 8N1, LSB first, BAUD_DIV clk cycles per bit.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   RX           : serial input (idles high)
//   TX           : serial output (idles high)
//   rx_rdy       : level, a received byte is waiting in rx_data
//   clr_rx_rdy   : consumer acknowledge for rx_rdy
//   rx_data      : last received byte
//   trmt         : start transmitting tx_data
//   tx_data      : byte to transmit
//   tx_done      : level, set after the stop bit, cleared by the next trmt
module UART #(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    output logic       TX,
    output logic       rx_rdy,
    input  logic       clr_rx_rdy,
    output logic [7:0] rx_data,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       tx_done
);

    localparam int CW = $clog2(BAUD_DIV + 1);
    localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2);

    typedef enum logic { U_RIDLE, U_RECV } urx_state_t;
    typedef enum logic { U_TIDLE, U_TSEND } utx_state_t;

    // ---------------- receiver ----------------
    urx_state_t    rx_state_q, rx_state_d;
    logic          rx_meta_q, rx_sync_q;
    logic [CW-1:0] rx_baud_q, rx_baud_d;
    logic [3:0]    rx_bits_q, rx_bits_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          rx_rdy_q, rx_rdy_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_state_q <= U_RIDLE;
            rx_baud_q  <= '0;
            rx_bits_q  <= '0;
            rx_shift_q <= '0;
            rx_rdy_q   <= 1'b0;
        end else begin
            rx_meta_q  <= RX;
            rx_sync_q  <= rx_meta_q;
            rx_state_q <= rx_state_d;
            rx_baud_q  <= rx_baud_d;
            rx_bits_q  <= rx_bits_d;
            rx_shift_q <= rx_shift_d;
            rx_rdy_q   <= rx_rdy_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_baud_d  = rx_baud_q;
        rx_bits_d  = rx_bits_q;
        rx_shift_d = rx_shift_q;
        rx_rdy_d   = rx_rdy_q;
        if (clr_rx_rdy) rx_rdy_d = 1'b0;
        case (rx_state_q)
            U_RIDLE: begin
                if (!rx_sync_q) begin
                    // first sample lands mid start bit
                    rx_state_d = U_RECV;
                    rx_baud_d  = HALF;
                    rx_bits_d  = '0;
                    rx_rdy_d   = 1'b0;
                end
            end
            U_RECV: begin
                if (rx_baud_q == '0) begin
                    rx_baud_d = FULL;
                    rx_bits_d = rx_bits_q + 4'd1;
                    if (rx_bits_q >= 4'd1 && rx_bits_q <= 4'd8)
                        rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    if (rx_bits_q == 4'd9) begin
                        rx_state_d = U_RIDLE;
                        rx_rdy_d   = 1'b1;
                    end
                end else begin
                    rx_baud_d = rx_baud_q - CW'(1);
                end
            end
            default: rx_state_d = U_RIDLE;
        endcase
    end

    assign rx_rdy  = rx_rdy_q;
    assign rx_data = rx_shift_q;

    // ---------------- transmitter ----------------
    utx_state_t    tx_state_q, tx_state_d;
    logic [9:0]    frame_q, frame_d;
    logic [CW-1:0] tx_baud_q, tx_baud_d;
    logic [3:0]    tx_bits_q, tx_bits_d;
    logic          tx_done_q, tx_done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= U_TIDLE;
            frame_q    <= '1;
            tx_baud_q  <= '0;
            tx_bits_q  <= '0;
            tx_done_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            frame_q    <= frame_d;
            tx_baud_q  <= tx_baud_d;
            tx_bits_q  <= tx_bits_d;
            tx_done_q  <= tx_done_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        frame_d    = frame_q;
        tx_baud_d  = tx_baud_q;
        tx_bits_d  = tx_bits_q;
        tx_done_d  = tx_done_q;
        if (trmt) begin
            frame_d    = {1'b1, tx_data, 1'b0};
            tx_baud_d  = FULL;
            tx_bits_d  = '0;
            tx_done_d  = 1'b0;
            tx_state_d = U_TSEND;
        end else if (tx_state_q == U_TSEND) begin
            if (tx_baud_q == '0) begin
                tx_baud_d = FULL;
                if (tx_bits_q == 4'd9) begin
                    tx_state_d = U_TIDLE;
                    tx_done_d  = 1'b1;
                end else begin
                    // shift in ones so the line rests high after the stop bit
                    frame_d   = {1'b1, frame_q[9:1]};
                    tx_bits_d = tx_bits_q + 4'd1;
                end
            end else begin
                tx_baud_d = tx_baud_q - CW'(1);
            end
        end
    end

    assign TX      = frame_q[0];
    assign tx_done = tx_done_q;

endmodule

// File: rtl/uart_cmd_framer.sv
// Command/response framer on top of the byte-level UART core.
// Assembles CMD_BYTES received bytes (first byte in the MSBs) into cmd,
// discards partial frames after TO_CYCLES idle clocks, and serialises a
// RESP_BYTES-wide response MSB byte first.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   RX, TX       : serial lines
//   cmd          : last completed command
//   cmd_rdy      : unconsumed command present
//   clr_cmd_rdy  : consumer acknowledge (clears cmd_rdy and cmd_ovr)
//   cmd_ovr      : sticky, a completed command was dropped
//   timeout_err  : one-cycle pulse when a partial frame is discarded
//   resp_trmt    : start a response (accepted only when idle)
//   resp_data    : response word, captured on acceptance
//   resp_busy    : response in progress
//   resp_done    : one-cycle pulse after the last response byte
module uart_cmd_framer
    import uart_cmd_pkg::*;
#(
    parameter int CMD_BYTES  = 2,
    parameter int RESP_BYTES = 1,
    parameter int TO_CYCLES  = 100000,
    parameter int BAUD_DIV   = 2604
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       RX,
    output logic                       TX,
    output logic [BYTE_W*CMD_BYTES-1:0] cmd,
    output logic                       cmd_rdy,
    input  logic                       clr_cmd_rdy,
    output logic                       cmd_ovr,
    output logic                       timeout_err,
    input  logic                       resp_trmt,
    input  logic [BYTE_W*RESP_BYTES-1:0] resp_data,
    output logic                       resp_busy,
    output logic                       resp_done
);

    localparam int CMD_W  = BYTE_W * CMD_BYTES;
    localparam int RESP_W = BYTE_W * RESP_BYTES;
    localparam int IDX_W  = $clog2(CMD_BYTES);
    localparam int TO_W   = $clog2(TO_CYCLES) + 1;
    localparam int REM_W  = $clog2(RESP_BYTES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CMD_BYTES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_CYCLES - 1);

    // UART core interface
    logic        rx_rdy;
    logic        clr_rx_rdy;
    logic [7:0]  rx_data;
    logic        trmt;
    logic [7:0]  tx_data;
    logic        tx_done;

    UART #(
        .BAUD_DIV(BAUD_DIV)
    ) u_uart (
        .clk        (clk),
        .rst_n      (rst_n),
        .RX         (RX),
        .TX         (TX),
        .rx_rdy     (rx_rdy),
        .clr_rx_rdy (clr_rx_rdy),
        .rx_data    (rx_data),
        .trmt       (trmt),
        .tx_data    (tx_data),
        .tx_done    (tx_done)
    );

    // ---------------- command assembler ----------------
    rx_state_t        rx_state_q, rx_state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CMD_W-1:0] asm_q, asm_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [CMD_W-1:0] cmd_q, cmd_d;
    logic             cmd_rdy_q, cmd_rdy_d;
    logic             cmd_ovr_q, cmd_ovr_d;
    logic             to_err_q, to_err_d;
    logic [CMD_W-1:0] asm_shift;
    logic             to_hit;

    assign asm_shift = {asm_q[CMD_W-BYTE_W-1:0], rx_data};
    assign to_hit    = (TO_CYCLES != 0) && (to_cnt_q == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q <= R_IDLE;
            idx_q      <= '0;
            asm_q      <= '0;
            to_cnt_q   <= '0;
            cmd_q      <= '0;
            cmd_rdy_q  <= 1'b0;
            cmd_ovr_q  <= 1'b0;
            to_err_q   <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            idx_q      <= idx_d;
            asm_q      <= asm_d;
            to_cnt_q   <= to_cnt_d;
            cmd_q      <= cmd_d;
            cmd_rdy_q  <= cmd_rdy_d;
            cmd_ovr_q  <= cmd_ovr_d;
            to_err_q   <= to_err_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        idx_d      = idx_q;
        asm_d      = asm_q;
        to_cnt_d   = to_cnt_q;
        cmd_d      = cmd_q;
        cmd_rdy_d  = cmd_rdy_q;
        cmd_ovr_d  = cmd_ovr_q;
        to_err_d   = 1'b0;
        clr_rx_rdy = 1'b0;

        if (clr_cmd_rdy) begin
            cmd_rdy_d = 1'b0;
            cmd_ovr_d = 1'b0;
        end

        case (rx_state_q)
            R_IDLE: begin
                to_cnt_d = '0;
                if (rx_rdy) begin
                    clr_rx_rdy = 1'b1;
                    asm_d      = asm_shift;
                    idx_d      = IDX_W'(1);
                    rx_state_d = R_ASM;
                end
            end
            R_ASM: begin
                if (to_hit) begin
                    to_err_d   = 1'b1;
                    to_cnt_d   = '0;
                    idx_d      = '0;
                    asm_d      = '0;
                    rx_state_d = R_IDLE;
                    // a byte landing in the timeout cycle opens a new frame
                    if (rx_rdy) begin
                        clr_rx_rdy = 1'b1;
                        asm_d      = CMD_W'(rx_data);
                        idx_d      = IDX_W'(1);
                        rx_state_d = R_ASM;
                    end
                end else if (rx_rdy) begin
                    clr_rx_rdy = 1'b1;
                    to_cnt_d   = '0;
                    if (idx_q == LAST_IDX) begin
                        idx_d      = '0;
                        asm_d      = '0;
                        rx_state_d = R_IDLE;
                        if (!cmd_rdy_q || clr_cmd_rdy) begin
                            // completion overrides a same-cycle clear entirely
                            cmd_d     = asm_shift;
                            cmd_rdy_d = 1'b1;
                            cmd_ovr_d = cmd_ovr_q;
                        end else begin
                            cmd_ovr_d = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        asm_d = asm_shift;
                    end
                end else if (TO_CYCLES != 0) begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            default: rx_state_d = R_IDLE;
        endcase
    end

    assign cmd         = cmd_q;
    assign cmd_rdy     = cmd_rdy_q;
    assign cmd_ovr     = cmd_ovr_q;
    assign timeout_err = to_err_q;

    // ---------------- response serialiser ----------------
    tx_state_t         tx_state_q, tx_state_d;
    logic [RESP_W-1:0] shreg_q, shreg_d;
    logic [REM_W-1:0]  rem_q, rem_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= T_IDLE;
            shreg_q    <= '0;
            rem_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            shreg_q    <= shreg_d;
            rem_q      <= rem_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        shreg_d    = shreg_q;
        rem_d      = rem_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        trmt       = 1'b0;
        case (tx_state_q)
            T_IDLE: begin
                if (resp_trmt) begin
                    shreg_d    = resp_data;
                    rem_d      = REM_W'(RESP_BYTES);
                    busy_d     = 1'b1;
                    tx_state_d = T_SEND;
                end
            end
            T_SEND: begin
                // one-cycle strobe; waiting a cycle lets the core drop the
                // previous byte's tx_done before it is looked at
                trmt       = 1'b1;
                tx_state_d = T_WAIT;
            end
            T_WAIT: begin
                if (tx_done) begin
                    shreg_d = shreg_q << BYTE_W;
                    rem_d   = rem_q - REM_W'(1);
                    if (rem_q == REM_W'(1)) begin
                        done_d     = 1'b1;
                        busy_d     = 1'b0;
                        tx_state_d = T_IDLE;
                    end else begin
                        tx_state_d = T_SEND;
                    end
                end
            end
            default: tx_state_d = T_IDLE;
        endcase
    end

    assign tx_data   = shreg_q[RESP_W-1 -: BYTE_W];
    assign resp_busy = busy_q;
    assign resp_done = done_q;

endmodule
